// File: rtl/product_accumulator.sv
// Group-wise accumulator for the multiplier product stream: sums products until
// in_last or MAX_TERMS, then presents sum, term count and sticky overflow.
module product_accumulator #(
  parameter int PROD_W    = 16,
  parameter int ACC_W     = 24,
  parameter int MAX_TERMS = 256,
  parameter bit SATURATE  = 1'b0,
  parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_overflow
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_DONE  = 1'b1;

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             ovf_sticky;

  logic [ACC_W:0]   sum_ext;
  logic             ovf_now;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] count_next;
  logic             accept;
  logic             close;

  assign in_ready  = (state == ST_ACCUM) && !rst;
  assign out_valid = (state == ST_DONE) && !rst;
  assign accept    = in_valid && in_ready;

  // The extra carry bit of sum_ext is the overflow indication for this term.
  always_comb begin
    sum_ext    = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};
    ovf_now    = sum_ext[ACC_W];
    acc_next   = sum_ext[ACC_W-1:0];
    if (ovf_now && SATURATE)
      acc_next = '1;
    count_next = count + CNT_W'(1);
    close      = in_last || (count_next == CNT_W'(MAX_TERMS));
  end

  // Accumulator state is cleared when the result is handed off, not at close.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_ACCUM;
      acc          <= '0;
      count        <= '0;
      ovf_sticky   <= 1'b0;
      out_sum      <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else if (state == ST_ACCUM) begin
      if (accept) begin
        if (close) begin
          state        <= ST_DONE;
          out_sum      <= acc_next;
          out_count    <= count_next;
          out_overflow <= ovf_sticky | ovf_now;
        end else begin
          acc        <= acc_next;
          count      <= count_next;
          ovf_sticky <= ovf_sticky | ovf_now;
        end
      end
    end else begin
      if (out_ready) begin
        state      <= ST_ACCUM;
        acc        <= '0;
        count      <= '0;
        ovf_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Sequential accumulator directly downstream of the 8-bit array multiplier.
- Consumes the 16-bit product stream over a valid/ready handshake and sums groups of products into a wide accumulator (dot-product / MAC tail).
- Emits one result per group, with term count and an overflow flag, over a second valid/ready handshake.

Parameters:
PROD_W, 16, width of incoming product
ACC_W, 24, accumulator and result width; must be >= PROD_W
MAX_TERMS, 256, maximum products per group; the group closes automatically on the MAX_TERMS-th accepted term
SATURATE, 0, 0 = wrap modulo 2^ACC_W on overflow; 1 = clamp to all-ones
CNT_W, $clog2(MAX_TERMS+1), width of term counter

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  product valid
in_ready  output  1  block can accept a product
in_product  input  PROD_W  unsigned product from multiplier
in_last  input  1  final product of the group; qualified by in_valid
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_sum  output  ACC_W  accumulated group sum
out_count  output  CNT_W  number of products in the group
out_overflow  output  1  sum exceeded ACC_W bits at least once in the group

Behaviour:
- One clock. Reset is synchronous and active-high; no asynchronous elements.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Reset values: state=ACCUM; acc, count and sticky overflow = 0; out_valid=0; out_sum, out_count, out_overflow = 0.
- in_ready is 0 during any cycle with rst high and 1 in the first cycle after rst deasserts.
- Accept: transfer occurs on in_valid && in_ready. in_product is zero-extended to ACC_W+1 bits and added to acc.
- Overflow: if bit ACC_W of the sum is 1, overflow is set (sticky for the group). Then:
  - SATURATE=0: acc takes the low ACC_W bits.
  - SATURATE=1: acc becomes 2^ACC_W-1 and stays clamped for the rest of the group.
- count increments on each accepted product.
- Group close: triggered by an accept with in_last=1, or by an accept that makes count equal MAX_TERMS (in_last ignored in that case). On close:
  - out_sum, out_count and out_overflow are registered from the post-add values.
  - State goes to DONE; out_valid=1 in the cycle after the closing accept (latency 1).
- DONE:
  - out_sum, out_count and out_overflow are held stable.
  - in_valid and in_product are ignored.
  - On out_valid && out_ready: next cycle state=ACCUM with acc, count and overflow cleared. out_valid=0 and in_ready=1 in that same cycle. out_* hold their last values (don't-care while out_valid=0).
- Throughput: a group of N terms takes at least N+1 cycles; one mandatory bubble during DONE.
- in_valid low in ACCUM: no state change; gaps are allowed anywhere in a group.
- Reset mid-group or in DONE: the partial or pending result is discarded and all state returns to reset values.
- No zero-length groups: a group always contains at least one accepted product.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0, out_sum=0, out_count=0, in_ready=0 during reset; in_ready=1 on the first cycle after.
- Basic group: products 100, 200, 300 with in_last on 300, out_ready=1 -> out_valid=1 for one cycle after the third accept; out_sum=600, out_count=3, out_overflow=0; in_ready=1 again the cycle after.
- Backpressure: close a group of 5 then 7 (sum 12), hold out_ready=0 for 5 cycles while driving in_valid=1 with value 9:
  - out_sum=12 and out_count=2 stay stable; in_ready=0; 9 is not accumulated.
  - Release out_ready -> the next group starts from acc=0.
- Overflow (ACC_W=17): three products 0xFFFF with in_last on the third:
  - SATURATE=0 -> out_sum=0x0FFFD, out_overflow=1.
  - SATURATE=1 -> out_sum=0x1FFFF, out_overflow=1.
  - Two products only -> out_sum=0x1FFFE, overflow=0.
- Auto-close: defaults, 256 products of value 1 with in_last=0 and random in_valid gaps -> out_count=256, out_sum=256. The 257th product forms a new group.
- Reset mid-group: accept 50 and 60, assert rst for 1 cycle, then accept 7 with in_last -> out_sum=7, out_count=1.
